cpu_run_checker: RTL and testbench

Synthesizable run checker that sits beside `cpu_top` and watches the retiring `pc` and `alu_result` stream against a programmed table of checkpoints. It replaces the fixed "wait 2020 ns, then look at `alu_result`" check with one driven by PC-matched, ordered checkpoints. It has a cycle watchdog and latched pass/fail/timeout status, so the same check runs in simulation and on the FPGA.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/chk_table.sv | 45 ++++
 rtl/cpu_run_checker.sv | 160 ++++++++++++++++
 tb/tb_cpu_run_checker.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the run checker: FSM state encoding and the
// checkpoint-count clamp used when a run is started.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        PASS = 3'd2,
        FAIL = 3'd3,
        TMO  = 3'd4
    } chk_state_t;

    // Requested checkpoint count forced into [1, n]; 0 would make the
    // "last entry" test underflow, so it is treated as a single checkpoint.
    function automatic int clamp_count(input int req, input int n);
        if (req < 1) return 1;
        if (req > n) return n;
        return req;
    endfunction

endpackage

// File: rtl/chk_table.sv
// Checkpoint register file: one synchronous write port, one
// asynchronous read port addressed by the run pointer.
module chk_table #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_CHECKS = 4,
    parameter int IDX_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [ADDR_W-1:0] wpc_i,
    input  logic [DATA_W-1:0] wexp_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [ADDR_W-1:0] rpc_o,
    output logic [DATA_W-1:0] rexp_o
);

    // Entry layout; kept local because the widths are module parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] exp_val;
    } chk_entry_t;

    chk_entry_t [N_CHECKS-1:0] tbl_q;

    // Entry write; an index with no matching entry simply writes nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_q <= '0;
        end else begin
            for (int i = 0; i < N_CHECKS; i++) begin
                if (we_i && widx_i == IDX_W'(i)) begin
                    tbl_q[i].pc      <= wpc_i;
                    tbl_q[i].exp_val <= wexp_i;
                end
            end
        end
    end

    assign rpc_o  = tbl_q[ridx_i].pc;
    assign rexp_o = tbl_q[ridx_i].exp_val;

endmodule

// File: rtl/cpu_run_checker.sv
// Run checker: walks an ordered checkpoint table against the retiring
// pc/alu_result stream, with a RUN-cycle watchdog and latched status.
module cpu_run_checker
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int N_CHECKS = 4,
    parameter int TIMEOUT  = 1024,
    localparam int IDX_W   = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_pc,
    input  logic [DATA_W-1:0] cfg_expect,
    input  logic [IDX_W:0]    cfg_count,
    input  logic              start,
    input  logic              clear,
    input  logic              mon_valid,
    input  logic [ADDR_W-1:0] mon_pc,
    input  logic [DATA_W-1:0] mon_result,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [DATA_W-1:0] fail_actual,
    output logic [CNT_W-1:0]  cycles
);

    localparam int CW = IDX_W + 1;

    chk_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic [IDX_W-1:0]  fidx_q, fidx_d;
    logic [DATA_W-1:0] fact_q, fact_d;

    logic [ADDR_W-1:0] tbl_pc;
    logic [DATA_W-1:0] tbl_exp;
    logic              hit, last, at_limit;

    // Writes only land while idle, so a running check sees a stable table.
    chk_table #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .N_CHECKS (N_CHECKS),
        .IDX_W    (IDX_W)
    ) u_tbl (
        .clk    (clk),
        .rst    (rst),
        .we_i   (cfg_we && state_q == IDLE),
        .widx_i (cfg_idx),
        .wpc_i  (cfg_pc),
        .wexp_i (cfg_expect),
        .ridx_i (ptr_q),
        .rpc_o  (tbl_pc),
        .rexp_o (tbl_exp)
    );

    assign hit      = mon_valid && (mon_pc == tbl_pc);
    assign last     = ({1'b0, ptr_q} == count_q - CW'(1));
    assign at_limit = (cycles_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state plus pointer/counter/capture updates.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        cycles_d = cycles_q;
        fidx_d   = fidx_q;
        fact_d   = fact_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    ptr_d    = '0;
                    cycles_d = '0;
                    count_d  = CW'(clamp_count(int'(cfg_count), N_CHECKS));
                end
            end
            RUN: begin
                cycles_d = cycles_q + CNT_W'(1);
                if (hit) begin
                    if (mon_result == tbl_exp) begin
                        if (last) state_d = PASS;
                        else      ptr_d   = ptr_q + IDX_W'(1);
                    end else begin
                        state_d = FAIL;
                        fidx_d  = ptr_q;
                        fact_d  = mon_result;
                    end
                end
                // Watchdog only fires when nothing else ended the run; the
                // reported index is the checkpoint still outstanding.
                if (state_d == RUN && at_limit) begin
                    state_d = TMO;
                    fidx_d  = ptr_d;
                end
            end
            PASS, FAIL, TMO: begin
                if (clear) begin
                    state_d  = IDLE;
                    ptr_d    = '0;
                    cycles_d = '0;
                    fidx_d   = '0;
                    fact_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= '0;
            count_q  <= '0;
            cycles_q <= '0;
            fidx_q   <= '0;
            fact_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            cycles_q <= cycles_d;
            fidx_q   <= fidx_d;
            fact_q   <= fact_d;
        end
    end

    // Status flags decoded from the registered state.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        pass    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            RUN:  busy = 1'b1;
            PASS: begin done = 1'b1; pass = 1'b1; end
            FAIL: done = 1'b1;
            TMO:  begin done = 1'b1; timeout = 1'b1; end
            default: ;
        endcase
    end

    assign fail_idx    = fidx_q;
    assign fail_actual = fact_q;
    assign cycles      = cycles_q;

endmodule

// File: tb/tb_cpu_run_checker.sv
// Randomised and directed bench for cpu_run_checker against an
// outcome-level reference model of the checkpoint walk.
module tb_cpu_run_checker;

    localparam int DW = 32, AW = 32, NC = 4, TO = 16, IW = 2, CNTW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cfg_we, start, clear, mon_valid;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_pc, mon_pc;
    logic [DW-1:0] cfg_expect, mon_result;
    logic [IW:0]   cfg_count;
    logic          busy, done, pass, timeout;
    logic [IW-1:0] fail_idx;
    logic [DW-1:0] fail_actual;
    logic [CNTW-1:0] cycles;

    cpu_run_checker #(.DATA_W(DW), .ADDR_W(AW), .N_CHECKS(NC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
        .cfg_expect(cfg_expect), .cfg_count(cfg_count), .start(start), .clear(clear),
        .mon_valid(mon_valid), .mon_pc(mon_pc), .mon_result(mon_result),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .fail_idx(fail_idx), .fail_actual(fail_actual), .cycles(cycles)
    );

    int checks = 0, failures = 0;

    // Reference table and the monitor stream for one scenario.
    logic [AW-1:0] m_pc [NC];
    logic [DW-1:0] m_exp[NC];
    bit            q_v  [$];
    logic [AW-1:0] q_pc [$];
    logic [DW-1:0] q_res[$];

    // Predicted outcome: kind 0 = pass, 1 = fail, 2 = timeout.
    int            e_kind, e_cyc, e_idx;
    logic [DW-1:0] e_act;

    function automatic void predict(input int cnt_req);
        int cnt, ptr;
        bit v;
        logic [AW-1:0] pc;
        logic [DW-1:0] r;
        cnt = (cnt_req < 1) ? 1 : ((cnt_req > NC) ? NC : cnt_req);
        ptr = 0; e_kind = 2; e_cyc = TO; e_idx = 0; e_act = '0;
        for (int t = 0; t < TO; t++) begin
            v  = (t < q_v.size()) ? q_v[t] : 1'b0;
            pc = (t < q_v.size()) ? q_pc[t] : '0;
            r  = (t < q_v.size()) ? q_res[t] : '0;
            if (v && pc == m_pc[ptr]) begin
                if (r == m_exp[ptr]) begin
                    if (ptr == cnt - 1) begin e_kind = 0; e_cyc = t + 1; return; end
                    ptr++;
                end else begin
                    e_kind = 1; e_cyc = t + 1; e_idx = ptr; e_act = r; return;
                end
            end
        end
        e_idx = ptr;
    endfunction

    task automatic q_reset();
        q_v.delete(); q_pc.delete(); q_res.delete();
    endtask

    task automatic push(input bit v, input logic [AW-1:0] pc, input logic [DW-1:0] r);
        q_v.push_back(v); q_pc.push_back(pc); q_res.push_back(r);
    endtask

    task automatic wr(input int idx, input logic [AW-1:0] pc, input logic [DW-1:0] e);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_pc = pc; cfg_expect = e;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_pc[idx] = pc; m_exp[idx] = e;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // Starts a run, plays the queued stream, returns how many monitor
    // cycles elapsed before done rose (-1 if it never did).
    task automatic run_scn(input int cnt_req, output int lat, output bit busy0);
        cfg_count = (IW + 1)'(cnt_req);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy0 = busy;
        lat = -1;
        for (int t = 0; t < TO + 4; t++) begin
            mon_valid  = (t < q_v.size()) ? q_v[t] : 1'b0;
            mon_pc     = (t < q_v.size()) ? q_pc[t] : '0;
            mon_result = (t < q_v.size()) ? q_res[t] : '0;
            @(posedge clk); #1;
            if (done) begin lat = t + 1; break; end
        end
        mon_valid = 1'b0;
    endtask

    task automatic test_reset();
        int lat; bit b0;
        rst = 1'b0; cfg_we = 0; cfg_idx = 0; cfg_pc = 0; cfg_expect = 0; cfg_count = 0;
        start = 0; clear = 0; mon_valid = 0; mon_pc = 0; mon_result = 0;
        for (int i = 0; i < NC; i++) begin m_pc[i] = '0; m_exp[i] = '0; end
        #12;
        checks++;
        if ({busy, done, pass, timeout, fail_idx, fail_actual, cycles} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b tmo=%b idx=%0d act=%h cyc=%0d, want all 0",
                     busy, done, pass, timeout, fail_idx, fail_actual, cycles);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        // A freshly reset table holds pc=0/expect=0 in every entry.
        q_reset(); push(1, 32'h0, 32'h0);
        run_scn(0, lat, b0);
        checks++;
        if (pass !== 1'b1 || cycles !== CNTW'(1)) begin
            failures++;
            $display("FAIL reset_table_zero: got pass=%b cycles=%0d, want pass=1 cycles=1", pass, cycles);
        end
        do_clear();
    endtask

    task automatic test_single_pass();
        int lat; bit b0;
        wr(0, 32'h4, 32'h1);
        q_reset(); push(0, 0, 0); push(0, 0, 0); push(0, 0, 0); push(1, 32'h4, 32'h1);
        run_scn(1, lat, b0);
        checks++;
        if (b0 !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", b0); end
        checks++;
        if (pass !== 1'b1 || timeout !== 1'b0 || cycles !== CNTW'(4)) begin
            failures++;
            $display("FAIL single_pass: got pass=%b tmo=%b cyc=%0d, want pass=1 tmo=0 cyc=4", pass, timeout, cycles);
        end
        checks++;
        if (lat != 4) begin failures++; $display("FAIL single_latency: got %0d want 4", lat); end
        do_clear();
    endtask

    task automatic test_ordered();
        int lat; bit b0;
        wr(0, 32'h10, 32'hA); wr(1, 32'h14, 32'hB); wr(2, 32'h18, 32'hC);
        q_reset();
        push(1, 32'h14, 32'hB); push(0, 0, 0); push(1, 32'h10, 32'hA); push(1, 32'h20, 32'h5);
        push(1, 32'h14, 32'hB); push(0, 0, 0); push(1, 32'h99, 32'h0); push(1, 32'h18, 32'hC);
        run_scn(3, lat, b0);
        checks++;
        if (pass !== 1'b1 || cycles !== CNTW'(8) || lat != 8) begin
            failures++;
            $display("FAIL ordered_pass: got pass=%b cyc=%0d lat=%0d, want pass=1 cyc=8 lat=8", pass, cycles, lat);
        end
        do_clear();
    endtask

    task automatic test_fail();
        int lat; bit b0;
        wr(0, 32'h10, 32'h1); wr(1, 32'h20, 32'h2);
        q_reset(); push(1, 32'h10, 32'h1); push(0, 0, 0); push(1, 32'h20, 32'hDEAD);
        run_scn(2, lat, b0);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || timeout !== 1'b0 || fail_idx !== IW'(1) || fail_actual !== 32'hDEAD) begin
            failures++;
            $display("FAIL mismatch_capture: got done=%b pass=%b tmo=%b idx=%0d act=%h, want 1 0 0 1 dead",
                     done, pass, timeout, fail_idx, fail_actual);
        end
        checks++;
        if (cycles !== CNTW'(3)) begin failures++; $display("FAIL mismatch_cycles: got %0d want 3", cycles); end
        do_clear();
    endtask

    task automatic test_timeout();
        int lat; bit b0;
        wr(0, 32'h40, 32'h1);
        q_reset();
        for (int i = 0; i < TO; i++) push(1, 32'h44, DW'($urandom_range(0, 3)));
        run_scn(1, lat, b0);
        checks++;
        if (timeout !== 1'b1 || pass !== 1'b0 || cycles !== CNTW'(16) || fail_idx !== IW'(0) || lat != 16) begin
            failures++;
            $display("FAIL timeout: got tmo=%b pass=%b cyc=%0d idx=%0d lat=%0d, want 1 0 16 0 16",
                     timeout, pass, cycles, fail_idx, lat);
        end
        do_clear();
        checks++;
        if ({busy, done, timeout, fail_idx, cycles} !== '0) begin
            failures++;
            $display("FAIL clear_idle: got busy=%b done=%b tmo=%b idx=%0d cyc=%0d, want all 0",
                     busy, done, timeout, fail_idx, cycles);
        end
    endtask

    task automatic test_edge();
        int lat; bit b0;
        wr(0, 32'h10, 32'h1); wr(1, 32'h20, 32'h2);
        q_reset(); push(1, 32'h10, 32'h1);
        for (int i = 1; i < TO - 1; i++) push(0, 0, 0);
        push(1, 32'h20, 32'h2);
        run_scn(2, lat, b0);
        checks++;
        if (pass !== 1'b1 || timeout !== 1'b0 || cycles !== CNTW'(16)) begin
            failures++;
            $display("FAIL edge_priority: got pass=%b tmo=%b cyc=%0d, want 1 0 16", pass, timeout, cycles);
        end
        do_clear();
    endtask

    task automatic test_reset_mid_run();
        wr(0, 32'h30, 32'h7);
        cfg_count = 1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mon_valid = 1'b1; mon_pc = 32'h99; mon_result = 32'h7;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, timeout, fail_idx, fail_actual, cycles} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b cyc=%0d, want all 0", busy, done, cycles);
        end
        mon_valid = 1'b0;
        for (int i = 0; i < NC; i++) begin m_pc[i] = '0; m_exp[i] = '0; end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        wr(0, 32'h30, 32'h7);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Write attempted while running must not disturb entry 0.
        cfg_we = 1'b1; cfg_idx = 0; cfg_pc = 32'h50; cfg_expect = 32'h9;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mon_valid = 1'b1; mon_pc = 32'h30; mon_result = 32'h7;
        @(posedge clk); #1;
        mon_valid = 1'b0;
        checks++;
        if (pass !== 1'b1 || cycles !== CNTW'(2)) begin
            failures++;
            $display("FAIL run_write_ignored: got pass=%b cyc=%0d, want 1 2", pass, cycles);
        end
        do_clear();
        // Write and start together: the write is in place for the run.
        cfg_we = 1'b1; cfg_idx = 0; cfg_pc = 32'h60; cfg_expect = 32'h3; start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        m_pc[0] = 32'h60; m_exp[0] = 32'h3;
        mon_valid = 1'b1; mon_pc = 32'h60; mon_result = 32'h3;
        @(posedge clk); #1;
        mon_valid = 1'b0;
        checks++;
        if (pass !== 1'b1 || cycles !== CNTW'(1)) begin
            failures++;
            $display("FAIL write_with_start: got pass=%b cyc=%0d, want 1 1", pass, cycles);
        end
        do_clear();
    endtask

    task automatic test_random();
        int lat, cnt, len, k;
        bit b0, v;
        logic [AW-1:0] pc;
        logic [DW-1:0] r;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NC; i++)
                if ($urandom_range(0, 1) == 1)
                    wr(i, AW'(32'h100 + 4 * $urandom_range(0, 7)), DW'($urandom_range(0, 3)));
            cnt = $urandom_range(0, 7);
            len = $urandom_range(4, 20);
            q_reset();
            for (int t = 0; t < len; t++) begin
                v = ($urandom_range(0, 3) != 0);
                k = $urandom_range(0, NC - 1);
                pc = ($urandom_range(0, 1) == 1) ? m_pc[k] : AW'(32'h100 + 4 * $urandom_range(0, 7));
                r  = ($urandom_range(0, 9) < 7) ? m_exp[k] : DW'($urandom_range(0, 3));
                push(v, pc, r);
            end
            predict(cnt);
            run_scn(cnt, lat, b0);
            checks++;
            if (done !== 1'b1 || pass !== (e_kind == 0) || timeout !== (e_kind == 2) ||
                cycles !== CNTW'(e_cyc) || lat != e_cyc) begin
                failures++;
                $display("FAIL random_outcome it=%0d: got done=%b pass=%b tmo=%b cyc=%0d lat=%0d, want kind=%0d cyc=%0d",
                         it, done, pass, timeout, cycles, lat, e_kind, e_cyc);
            end
            checks++;
            if (fail_idx !== ((e_kind == 0) ? IW'(0) : IW'(e_idx)) ||
                fail_actual !== ((e_kind == 1) ? e_act : '0)) begin
                failures++;
                $display("FAIL random_capture it=%0d: got idx=%0d act=%h, want idx=%0d act=%h",
                         it, fail_idx, fail_actual, (e_kind == 0) ? 0 : e_idx, (e_kind == 1) ? e_act : '0);
            end
            do_clear();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL random_clear it=%0d: got done=%b busy=%b, want 0 0", it, done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_ordered();
        test_fail();
        test_timeout();
        test_edge();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
